led_fade_pwm: RTL and testbench
===============================

Name: led_fade_pwm

Overview:
- Output stage directly downstream of the 4-LED flow-pattern generator.
- Consumes its 4-bit on/off pattern and drives the physical LED pins with per-channel PWM.
- Each channel's brightness ramps linearly toward the commanded level, so pattern steps appear as soft fades rather than hard switching.
- Global brightness ceiling and fade bypass come from board-level configuration.

Parameters:
- PWM_BITS, 8: brightness/PWM resolution; PWM_MAX = 2^PWM_BITS - 1.
- STEP_CYCLES, 39216: sys_clk cycles per fade step (full 0->255 ramp ≈ 0.2 s at 50 MHz); legal range ≥ 2.

Ports:
- sys_clk  input  1  system clock
- sys_rst_n  input  1  asynchronous reset, active low
- pat_in  input  4  on/off pattern from the flow generator; bit i = LED i commanded on
- bright_max  input  PWM_BITS  level used for an "on" bit; treated as static but may change at any time
- fade_en  input  1  1 = ramp brightness; 0 = level jumps to target (bypass)
- led_out  output  4  PWM-driven LED pins, 1 = lit
- busy  output  1  1 while any channel level differs from its target

Behaviour:
- Reset (async assert, sync release): pat_q=0, step_cnt=0, pwm_cnt=0, all levels=0, led_out=4'b0000, busy=0.
- Input capture: pat_q <= pat_in each cycle (1 register stage); target_i = pat_q[i] ? bright_max : 0.
- Step prescaler: step_cnt counts 0..STEP_CYCLES-1 and wraps to 0. step_tick=1 for the single cycle in which step_cnt==STEP_CYCLES-1. The prescaler is free-running and is never restarted by pattern changes.
- Level update, per channel, PWM_BITS wide:
  - fade_en=0: level_i <= target_i every cycle.
  - fade_en=1 and step_tick: level_i +1 if level_i<target_i; -1 if level_i>target_i; hold if equal.
  - fade_en=1 and no tick: hold.
- Level arithmetic: exactly ±1 per tick, no overshoot, no wrap. A level never passes 0 or PWM_MAX.
- Target change mid-ramp: the ramp reverses or retargets on the next tick from the current level. There is no restart from the endpoint.
- bright_max lowered below a lit channel's level: the channel ramps down to the new bright_max (or jumps down, if fade_en=0).
- PWM counter: pwm_cnt counts 0..PWM_MAX-1 and wraps, giving a period of PWM_MAX cycles.
  - led_out[i] <= (pwm_cnt < level_i), registered.
  - level 0 -> always off; level PWM_MAX -> always on; duty = level/PWM_MAX.
- Latency: a pat_in edge reaches target_i after 1 cycle. With fade_en=0, the new level reaches led_out 2 cycles after that, i.e. 3 cycles from the pat_in edge.
- busy <= OR over i of (level_i != target_i), registered (1-cycle lag vs level).
- fade_en toggled 0->1 mid-operation: ramping resumes from current levels with no glitch. 1->0: the next cycle snaps to target.
- Simultaneous step_tick and target change: the tick acts on the new target_i.
- No handshake: pat_in is a level input sampled every cycle; glitches shorter than one step only perturb the level by at most 1.

Decomposition:
- Shared package led_pkg: LED_NUM=4, default PWM_BITS, default STEP_CYCLES, and a typedef for the brightness level type.
- One natural sub-module, led_fade_channel, instantiated 4×. It holds level_i, target compare, ramp and PWM compare.
- Shared logic stays in the top: step prescaler, pwm_cnt, pat_q register, busy OR.

Test Plan (bench overrides PWM_BITS=4 (PWM_MAX=15), STEP_CYCLES=4):
- Reset check: hold sys_rst_n=0 with pat_in=4'b1111 -> led_out=0000, busy=0. Assert reset mid-ramp -> all outputs 0 in the same cycle, asynchronously.
- Ramp up: fade_en=1, bright_max=15, pat_in 0000->1000.
  - level_3 increments once every 4 cycles and reaches 15 after 60 cycles.
  - busy=1 during the ramp, 0 one cycle after the level hits 15.
  - Once at 15, led_out[3] is constant 1.
- Duty check: fade_en=0, bright_max=5, pat_in=0101 -> led_out[0] and led_out[2] high for exactly 5 of every 15 cycles. led_out[1] and led_out[3] stay 0.
- Reversal mid-ramp: fade_en=1; ramp channel 0 to level 7, then pat_in[0]=0 -> the next tick gives 6, and the level reaches 0 after 7 further ticks, with no step jumps.
- Ceiling lowered: channel at 15 steady, bright_max 15->3 with fade_en=1 -> level descends 15..3 over 12 ticks, then holds at 3 and busy drops.
- Bypass latency: fade_en=0, bright_max=15, pat_in 0000->1111 at cycle N -> busy stays 0 and led_out=1111 from cycle N+3.

Source files
------------

// File: rtl/led_pkg.sv
// Shared constants and types for the LED fade/PWM output stage.
package led_pkg;
  localparam int LED_NUM         = 4;
  localparam int PWM_BITS_DEF    = 8;
  localparam int STEP_CYCLES_DEF = 39216;

  typedef logic [PWM_BITS_DEF-1:0] level_t;
endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level register, linear ramp toward target, PWM compare.
module led_fade_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [PWM_BITS-1:0] target,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                fade_en,
  input  logic                step_tick,
  output logic                led,
  output logic                ramping
);

  logic [PWM_BITS-1:0] level;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      level <= '0;
      led   <= 1'b0;
    end else begin
      if (!fade_en) begin
        level <= target;
      end else if (step_tick) begin
        // Single-step moves can never overshoot the target, so no wrap guard is needed.
        if (level < target) begin
          level <= level + PWM_BITS'(1);
        end else if (level > target) begin
          level <= level - PWM_BITS'(1);
        end
      end
      led <= (pwm_cnt < level);
    end
  end

  // In bypass the level snaps every cycle, so that one-cycle lag is not a ramp.
  assign ramping = fade_en && (level != target);

endmodule

// File: rtl/led_fade_pwm.sv
// LED output stage: captures the flow pattern and drives each pin with a fading PWM level.
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int STEP_CYCLES = STEP_CYCLES_DEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic [3:0]          pat_in,
  input  logic [PWM_BITS-1:0] bright_max,
  input  logic                fade_en,
  output logic [3:0]          led_out,
  output logic                busy
);

  // No valid/ready handshake: pat_in, bright_max and fade_en are level inputs sampled every cycle.
  localparam int STEP_W = $clog2(STEP_CYCLES);
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] PWM_WRAP  = {{(PWM_BITS-1){1'b1}}, 1'b0};

  logic [LED_NUM-1:0]  pat_q;
  logic [STEP_W-1:0]   step_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                step_tick;
  logic [LED_NUM-1:0]  ramping;
  logic [PWM_BITS-1:0] target [LED_NUM];

  assign step_tick = (step_cnt == STEP_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pat_q    <= '0;
      step_cnt <= '0;
      pwm_cnt  <= '0;
      busy     <= 1'b0;
    end else begin
      pat_q    <= pat_in;
      step_cnt <= step_tick ? '0 : step_cnt + STEP_W'(1);
      pwm_cnt  <= (pwm_cnt == PWM_WRAP) ? '0 : pwm_cnt + PWM_BITS'(1);
      busy     <= |ramping;
    end
  end

  for (genvar i = 0; i < LED_NUM; i++) begin : g_ch
    assign target[i] = pat_q[i] ? bright_max : '0;

    led_fade_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .target    (target[i]),
      .pwm_cnt   (pwm_cnt),
      .fade_en   (fade_en),
      .step_tick (step_tick),
      .led       (led_out[i]),
      .ramping   (ramping[i])
    );
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Bench for led_fade_pwm: cycle-level behavioural model plus directed scenarios with literal checks.
module tb_led_fade_pwm;
  localparam int PWM_BITS = 4;
  localparam int STEP     = 4;
  localparam int PMAX     = 15;

  logic       sys_clk    = 1'b0;
  logic       sys_rst_n  = 1'b0;
  logic [3:0] pat_in     = '0;
  logic [3:0] bright_max = '0;
  logic       fade_en    = 1'b0;
  logic [3:0] led_out;
  logic       busy;

  int n_cmp   = 0;
  int n_err   = 0;
  bit run_cmp = 1'b0;

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  led_fade_pwm #(
    .PWM_BITS    (PWM_BITS),
    .STEP_CYCLES (STEP)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .pat_in     (pat_in),
    .bright_max (bright_max),
    .fade_en    (fade_en),
    .led_out    (led_out),
    .busy       (busy)
  );

  // behavioural model: m_k is the index of the clock edge since reset release
  int         m_k;
  logic [3:0] m_pat;
  int         m_lvl [4];
  logic [3:0] m_led;
  logic       m_busy;

  function automatic int tgt_of(input int i);
    return m_pat[i] ? int'(bright_max) : 0;
  endfunction

  function automatic int next_lvl(input int l, input int t);
    if (!fade_en) return t;
    if ((m_k % STEP) != STEP - 1) return l;
    if (l < t) return l + 1;
    if (l > t) return l - 1;
    return l;
  endfunction

  function automatic bit any_diff();
    for (int i = 0; i < 4; i++) if (m_lvl[i] != tgt_of(i)) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_k    <= 0;
      m_pat  <= '0;
      m_led  <= '0;
      m_busy <= 1'b0;
      for (int i = 0; i < 4; i++) m_lvl[i] <= 0;
    end else begin
      m_k    <= m_k + 1;
      m_pat  <= pat_in;
      m_busy <= fade_en && any_diff();
      for (int i = 0; i < 4; i++) begin
        m_led[i] <= ((m_k % PMAX) < m_lvl[i]);
        m_lvl[i] <= next_lvl(m_lvl[i], tgt_of(i));
      end
    end
  end

  // scoreboard
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge sys_clk) begin
    if (run_cmp) begin
      chk("model_led_out", int'(led_out), int'(m_led));
      chk("model_busy", int'(busy), int'(m_busy));
    end
  end

  // driver: reset with new inputs, release on a falling edge so the next rising edge is edge 0
  task automatic start(input logic fe, input logic [3:0] bm, input logic [3:0] pat);
    sys_rst_n  = 1'b0;
    fade_en    = fe;
    bright_max = bm;
    pat_in     = pat;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  int hi, ones, bad, c0, c1, c2, c3;

  initial begin
    // reset holds everything dark even with the pattern fully on
    pat_in = 4'b1111; bright_max = 4'd15; fade_en = 1'b1; sys_rst_n = 1'b0;
    run_cmp = 1'b1;
    repeat (3) @(negedge sys_clk);
    chk("reset_led_out", int'(led_out), 0);
    chk("reset_busy", int'(busy), 0);

    // ramp up channel 3: 15 ticks at edges 3..59, busy high after edges 1..59
    start(1'b1, 4'd15, 4'b1000);
    hi = 0; ones = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge sys_clk); #1;
      if (busy) hi++;
      if (c >= 61 && c <= 75 && led_out[3]) ones++;
    end
    chk("ramp_busy_cycles", hi, 59);
    chk("ramp_full_on", ones, 15);

    // asynchronous reset between clock edges
    @(posedge sys_clk); #3;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_led_out", int'(led_out), 0);
    chk("async_rst_busy", int'(busy), 0);

    // reversal: level 7 after edge 27, then descend 6..0 ending at edge 55
    start(1'b1, 4'd15, 4'b0001);
    hi = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge sys_clk); #1;
      if (busy) hi++;
      if (c == 27) pat_in = 4'b0000;
    end
    chk("rev_busy_cycles", hi, 55);

    // ceiling lowered 15 -> 3 with fading: 12 ticks at edges 11..55
    start(1'b0, 4'd15, 4'b0001);
    hi = 0; ones = 0;
    for (int c = 0; c < 80; c++) begin
      @(posedge sys_clk); #1;
      if (busy) hi++;
      if (c >= 60 && c <= 74 && led_out[0]) ones++;
      if (c == 9) begin
        fade_en    = 1'b1;
        bright_max = 4'd3;
      end
    end
    chk("ceil_busy_cycles", hi, 46);
    chk("ceil_duty", ones, 3);

    // bypass latency: pattern changes before edge 5, pins lit from edge 7
    start(1'b0, 4'd15, 4'b0000);
    ones = 0; bad = 0;
    for (int c = 0; c < 21; c++) begin
      @(posedge sys_clk); #1;
      if (busy) bad++;
      if (c == 6) chk("byp_before", int'(led_out), 0);
      if (c >= 7 && led_out == 4'b1111) ones++;
      if (c == 4) pat_in = 4'b1111;
    end
    chk("byp_on_cycles", ones, 14);
    chk("byp_busy", bad, 0);

    // duty: level 5 of 15
    fade_en = 1'b0; bright_max = 4'd5; pat_in = 4'b0101;
    repeat (6) @(posedge sys_clk);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    for (int c = 0; c < PMAX; c++) begin
      @(posedge sys_clk); #1;
      c0 += int'(led_out[0]);
      c1 += int'(led_out[1]);
      c2 += int'(led_out[2]);
      c3 += int'(led_out[3]);
    end
    chk("duty_ch0", c0, 5);
    chk("duty_ch1", c1, 0);
    chk("duty_ch2", c2, 5);
    chk("duty_ch3", c3, 0);

    @(negedge sys_clk);
    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
